// File: rtl/core_mem_arbiter_pkg.sv
// Shared memory-bus widths, arbiter selection states and port identifiers
// for the core memory arbiter.
package core_mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_F = 2'd1,
    LOCK_D = 2'd2
  } sel_state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/core_mem_arbiter.sv
// Two-to-one arbiter sharing the core memory bus between the fetch port and the
// data port, with handshake locking, response routing and fetch anti-starvation.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  f_req,
  input  logic [MEM_ADDR_W-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_err,
  output logic [MEM_DATA_W-1:0] f_rdata,
  input  logic                  d_req,
  input  logic [MEM_ADDR_W-1:0] d_addr,
  input  logic                  d_wen,
  input  logic [MEM_STRB_W-1:0] d_strb,
  input  logic [MEM_DATA_W-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_err,
  output logic [MEM_DATA_W-1:0] d_rdata,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  sel_state_t sel_state, sel_state_next;
  logic [3:0] starve_cnt, starve_cnt_next;
  logic       rsp_v;
  logic       rsp_own;
  logic       sel;
  logic       any_req;
  logic       xfer;

  assign any_req = f_req || d_req;
  assign xfer    = g_resetn && any_req && mem_gnt;

  always_comb begin
    sel = PORT_F;
    case (sel_state)
      LOCK_F:  sel = PORT_F;
      LOCK_D:  sel = PORT_D;
      default: if (d_req && (!f_req || (starve_cnt < LIMIT))) sel = PORT_D;
    endcase
  end

  // A locked requester that drops req releases the lock rather than wedging the bus.
  always_comb begin
    sel_state_next = sel_state;
    case (sel_state)
      LOCK_F:  if (mem_gnt || !f_req) sel_state_next = IDLE;
      LOCK_D:  if (mem_gnt || !d_req) sel_state_next = IDLE;
      default: if (any_req && !mem_gnt) sel_state_next = (sel == PORT_D) ? LOCK_D : LOCK_F;
    endcase
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (xfer) begin
      if ((sel == PORT_F) || !f_req) starve_cnt_next = '0;
      else if (starve_cnt < LIMIT)   starve_cnt_next = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      sel_state  <= IDLE;
      starve_cnt <= '0;
      rsp_v      <= 1'b0;
      rsp_own    <= PORT_F;
    end else begin
      sel_state  <= sel_state_next;
      starve_cnt <= starve_cnt_next;
      rsp_v      <= xfer;
      rsp_own    <= sel;
    end
  end

  assign mem_req   = g_resetn && any_req;
  assign mem_addr  = (sel == PORT_D) ? d_addr : f_addr;
  assign mem_wen   = (sel == PORT_D) && d_wen;
  assign mem_strb  = (sel == PORT_D) ? d_strb : '0;
  assign mem_wdata = (sel == PORT_D) ? d_wdata : '0;

  assign f_gnt = g_resetn && mem_gnt && (sel == PORT_F);
  assign d_gnt = g_resetn && mem_gnt && (sel == PORT_D);

  // Errors follow the registered owner; rdata is shared and qualified by each consumer.
  assign f_err   = g_resetn && rsp_v && (rsp_own == PORT_F) && mem_err;
  assign d_err   = g_resetn && rsp_v && (rsp_own == PORT_D) && mem_err;
  assign f_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  lock_f_holds_req: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (sel_state == LOCK_F) |-> f_req);
  lock_d_holds_req: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (sel_state == LOCK_D) |-> d_req);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed testbench for core_mem_arbiter with hand-computed expectations.
module tb_core_mem_arbiter;
  import core_mem_arbiter_pkg::*;

  logic                  g_clk;
  logic                  g_resetn;
  logic                  f_req;
  logic [MEM_ADDR_W-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_err;
  logic [MEM_DATA_W-1:0] f_rdata;
  logic                  d_req;
  logic [MEM_ADDR_W-1:0] d_addr;
  logic                  d_wen;
  logic [MEM_STRB_W-1:0] d_strb;
  logic [MEM_DATA_W-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_err;
  logic [MEM_DATA_W-1:0] d_rdata;
  logic                  mem_req;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_wen;
  logic [MEM_STRB_W-1:0] mem_strb;
  logic [MEM_DATA_W-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_err;
  logic [MEM_DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Contention pattern with STARVE_LIMIT=4: four data grants, then fetch.
  int exp_d[10]   = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int exp_cnt[10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

  core_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_strb(d_strb), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    g_resetn = 1'b0;
    f_req = 1'b1; f_addr = '0;
    d_req = 1'b1; d_addr = '0; d_wen = 1'b0; d_strb = '0; d_wdata = '0;
    mem_gnt = 1'b1; mem_err = 1'b1; mem_rdata = '0;
    #2;
    check("rst_mem_req",  64'(mem_req), 64'd0);
    check("rst_f_gnt",    64'(f_gnt), 64'd0);
    check("rst_d_gnt",    64'(d_gnt), 64'd0);
    check("rst_f_err",    64'(f_err), 64'd0);
    check("rst_d_err",    64'(d_err), 64'd0);
    check("rst_state",    64'(dut.sel_state), 64'(IDLE));
    check("rst_cnt",      64'(dut.starve_cnt), 64'd0);
    @(posedge g_clk); @(posedge g_clk); #1;
    f_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_err = 1'b0;
    #2 g_resetn = 1'b1;
    cyc();

    // Fetch only: four back-to-back transfers, rdata one cycle later.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        f_req = 1'b1; f_addr = 32'h100 + 32'(i * 4); mem_gnt = 1'b1;
      end else begin
        f_req = 1'b0; mem_gnt = 1'b0;
      end
      if (i > 0) mem_rdata = 64'hF00D_0000_0000_0000 | 64'(i - 1);
      #1;
      if (i < 4) begin
        check("fo_mem_req",  64'(mem_req), 64'd1);
        check("fo_mem_addr", 64'(mem_addr), 64'(32'h100 + 32'(i * 4)));
        check("fo_f_gnt",    64'(f_gnt), 64'd1);
        check("fo_d_gnt",    64'(d_gnt), 64'd0);
        check("fo_mem_wen",  64'(mem_wen), 64'd0);
      end
      if (i > 0) begin
        check("fo_f_rdata", f_rdata, 64'hF00D_0000_0000_0000 | 64'(i - 1));
        check("fo_f_err",   64'(f_err), 64'd0);
      end
      cyc();
    end

    // Contention: D,D,D,D,F repeating.
    f_addr = 32'h200; d_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      f_req = 1'b1; d_req = 1'b1; mem_gnt = 1'b1;
      #1;
      check("ct_cnt",      64'(dut.starve_cnt), 64'(exp_cnt[i]));
      check("ct_d_gnt",    64'(d_gnt), 64'(exp_d[i]));
      check("ct_f_gnt",    64'(f_gnt), 64'(exp_d[i] == 0));
      check("ct_mem_addr", 64'(mem_addr), (exp_d[i] != 0) ? 64'h300 : 64'h200);
      cyc();
    end

    // Lock hold: fetch stalled three cycles while data arrives.
    f_req = 1'b1; d_req = 1'b0; f_addr = 32'h400; d_addr = 32'h500; mem_gnt = 1'b0;
    #1;
    check("lk0_mem_addr", 64'(mem_addr), 64'h400);
    check("lk0_f_gnt",    64'(f_gnt), 64'd0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      d_req = 1'b1;
      #1;
      check("lk_state",    64'(dut.sel_state), 64'(LOCK_F));
      check("lk_mem_addr", 64'(mem_addr), 64'h400);
      check("lk_d_gnt",    64'(d_gnt), 64'd0);
      cyc();
    end
    mem_gnt = 1'b1;
    #1;
    check("lk3_f_gnt",    64'(f_gnt), 64'd1);
    check("lk3_d_gnt",    64'(d_gnt), 64'd0);
    check("lk3_mem_addr", 64'(mem_addr), 64'h400);
    cyc();
    #1;
    check("lk4_state",    64'(dut.sel_state), 64'(IDLE));
    check("lk4_d_gnt",    64'(d_gnt), 64'd1);
    check("lk4_mem_addr", 64'(mem_addr), 64'h500);
    cyc();

    // Error routing: data read in N, fetch in N+1, mem_err only in N+1.
    f_req = 1'b0; d_req = 1'b1; mem_gnt = 1'b1; mem_err = 1'b0;
    #1;
    check("er0_d_gnt", 64'(d_gnt), 64'd1);
    check("er0_d_err", 64'(d_err), 64'd0);
    cyc();
    f_req = 1'b1; d_req = 1'b0; mem_err = 1'b1;
    #1;
    check("er1_f_gnt", 64'(f_gnt), 64'd1);
    check("er1_d_err", 64'(d_err), 64'd1);
    check("er1_f_err", 64'(f_err), 64'd0);
    cyc();
    f_req = 1'b0; mem_gnt = 1'b0; mem_err = 1'b0;
    #1;
    check("er2_f_err", 64'(f_err), 64'd0);
    check("er2_d_err", 64'(d_err), 64'd0);
    cyc();

    // Write passthrough, then a fetch must not leak write payload.
    d_req = 1'b1; d_wen = 1'b1; d_strb = 8'hF0; d_wdata = 64'hDEADBEEF_00000000;
    d_addr = 32'h600; mem_gnt = 1'b1;
    #1;
    check("wr_d_gnt",     64'(d_gnt), 64'd1);
    check("wr_mem_wen",   64'(mem_wen), 64'd1);
    check("wr_mem_strb",  64'(mem_strb), 64'hF0);
    check("wr_mem_wdata", mem_wdata, 64'hDEADBEEF_00000000);
    check("wr_mem_addr",  64'(mem_addr), 64'h600);
    cyc();
    f_req = 1'b1; d_req = 1'b0; f_addr = 32'h700;
    #1;
    check("fw_f_gnt",     64'(f_gnt), 64'd1);
    check("fw_mem_wen",   64'(mem_wen), 64'd0);
    check("fw_mem_strb",  64'(mem_strb), 64'd0);
    check("fw_mem_wdata", mem_wdata, 64'd0);
    cyc();

    // Async reset while in LOCK_D with a nonzero starvation count.
    d_wen = 1'b0; f_req = 1'b1; d_req = 1'b1; mem_gnt = 1'b1;
    #1;
    check("ar0_d_gnt", 64'(d_gnt), 64'd1);
    cyc();
    f_req = 1'b0; d_req = 1'b1; mem_gnt = 1'b0;
    #1;
    check("ar1_d_gnt", 64'(d_gnt), 64'd0);
    cyc();
    #1;
    check("ar2_state",   64'(dut.sel_state), 64'(LOCK_D));
    check("ar2_cnt",     64'(dut.starve_cnt), 64'd1);
    check("ar2_mem_req", 64'(mem_req), 64'd1);
    #2;
    g_resetn = 1'b0; mem_gnt = 1'b1; mem_err = 1'b1;
    #1;
    check("ar3_mem_req", 64'(mem_req), 64'd0);
    check("ar3_d_gnt",   64'(d_gnt), 64'd0);
    check("ar3_f_gnt",   64'(f_gnt), 64'd0);
    check("ar3_d_err",   64'(d_err), 64'd0);
    check("ar3_state",   64'(dut.sel_state), 64'(IDLE));
    check("ar3_cnt",     64'(dut.starve_cnt), 64'd0);
    @(posedge g_clk);
    #3;
    f_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_err = 1'b0;
    g_resetn = 1'b1;
    cyc();
    #1;
    check("ar4_state", 64'(dut.sel_state), 64'(IDLE));
    check("ar4_cnt",   64'(dut.starve_cnt), 64'd0);
    check("ar4_f_err", 64'(f_err), 64'd0);
    check("ar4_d_err", 64'(d_err), 64'd0);
    f_req = 1'b1; d_req = 1'b1; mem_gnt = 1'b1;
    #1;
    check("ar4_d_gnt", 64'(d_gnt), 64'd1);
    cyc();
    f_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
